// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first.
// Result, carry and overflow are published together when the last bit lands.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_nxt;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             sum;
  logic             carry;
  logic             last;

  always_comb begin
    sum   = a_sr[0] ^ b_sr[0] ^ c;
    carry = (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0]));
    last  = (cnt == CW'(WIDTH - 1));
    r_nxt = {sum, r_sr[WIDTH-1:1]};
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      S    <= '0;
      Cout <= 1'b0;
      V    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr <= A;
            b_sr <= B;
            c    <= Cin;
            cnt  <= '0;
          end
        end
        ADD: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= r_nxt;
          c    <= carry;
          cnt  <= cnt + CW'(1);
          // c is still the carry into the MSB on the final step
          if (last) begin
            S    <= r_nxt;
            Cout <= carry;
            V    <= c ^ carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ADD);
  assign done = (state == DONE);

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; SHALL be legal for 2 to 32.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  the reset; it SHALL be synchronous and active-low.
REQ-004 start  input  1  request pulse; it SHALL be sampled only in IDLE.
REQ-005 A  input  WIDTH  minuend-side operand (addend), unsigned or two's complement.
REQ-006 B  input  WIDTH  second addend.
REQ-007 Cin  input  1  carry into bit 0.
REQ-008 busy  output  1  SHALL be high while an addition is in progress (state ADD).
REQ-009 done  output  1  SHALL be a one-cycle pulse marking a valid result.
REQ-010 S  output  WIDTH  sum, A+B+Cin modulo 2^WIDTH.
REQ-011 Cout  output  1  carry out of bit WIDTH-1.
REQ-012 V  output  1  two's-complement overflow, i.e. carry into MSB XOR Cout.

Function
REQ-013 FSM states SHALL be IDLE, ADD and DONE, encoded in a registered state variable.
REQ-014 IDLE, start=1: A, B and Cin SHALL be captured into internal shift registers and a carry flop; bit counter SHALL be cleared; next state SHALL be ADD.
REQ-015 IDLE, start=0: the state SHALL stay IDLE; S, Cout and V SHALL hold their previous values.
REQ-016 ADD, per edge: one full-adder step SHALL be done on the operand LSBs: sum = a0^b0^c, carry = a0&b0 | c&(a0^b0).
REQ-017 ADD, same edge: the sum bit SHALL shift into the result register MSB with a right shift, the operand registers SHALL shift right, and the counter SHALL increment.
REQ-018 Exactly WIDTH ADD edges SHALL be executed; on the WIDTH-th, S, Cout and V SHALL be updated and the state SHALL go to DONE.
REQ-019 Latency: if start is sampled at edge E, done SHALL be high for the cycle after edge E+WIDTH, and for that cycle only.
REQ-020 DONE SHALL always return to IDLE on the next edge.
REQ-021 start SHALL be ignored in ADD and DONE; there is no queuing, and a start coinciding with done is lost.
REQ-022 A, B and Cin SHALL be don't-care after the capture edge; changing them during ADD SHALL NOT affect the result.
REQ-023 S, Cout and V SHALL stay stable from the done cycle until the next completed operation; the internal partial result SHALL NOT be visible on S during ADD.
REQ-024 Back-to-back: start high continuously SHALL give one operation per WIDTH+2 cycles.
REQ-025 Counter width SHALL be clog2(WIDTH)+1 bits; there SHALL be no wrap within an operation.

Reset
REQ-026 When rst_n=0 at an edge, the state SHALL go to IDLE and busy=0, done=0, S=0, Cout=0, V=0; the counter, shift registers and carry flop SHALL clear.
REQ-027 Reset SHALL take priority over start and over any in-progress ADD; an aborted operation SHALL produce no done pulse.
REQ-028 After release, the first start SHALL be accepted on the first edge with rst_n=1.

Verification (WIDTH=8)
REQ-029 A=0x5A, B=0x33, Cin=0, start at edge E -> busy for 8 cycles, done in the cycle after E+8, S=0x8D, Cout=0, V=1.
REQ-030 A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1, V=0; A=0x80, B=0x80, Cin=0 -> S=0x00, Cout=1, V=1.
REQ-031 A=0x00, B=0x00, Cin=1 -> S=0x01, Cout=0, V=0; A=0x7F, B=0x00, Cin=1 -> S=0x80, Cout=0, V=1.
REQ-032 Start with 0x12+0x34, change A/B mid-ADD and pulse start during ADD -> single done, S=0x46, no second operation.
REQ-033 Start with 0xFF+0xFF, assert rst_n=0 at the 4th ADD edge -> all outputs 0, no done; a subsequent 0x01+0x02 yields S=0x03.
REQ-034 start held high for 3 operations -> done pulses exactly 10 cycles apart; random self-checking run (10k vectors, WIDTH 8 and 16) matches A+B+Cin.
